// File: rtl/operand_sel_if.sv
// Bus bundle for operand_sel_stage: input beat (operands, select, mode) and output beat with valid/ready.
// The design uses the slave modport and the source/sink side uses the master modport.
interface operand_sel_if #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int NUM_REG = 2,
    parameter int SEL_W   = $clog2(NUM_REG + 2)
);
    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_REG*DATA_W-1:0]   reg_data;
    logic [IMM_W-1:0]            imm;
    logic [SEL_W-1:0]            sel;
    logic [1:0]                  ext_mode;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W-1:0]           out_data;
    logic                        out_is_imm;
    logic                        out_err;

    modport master (
        output in_valid, reg_data, imm, sel, ext_mode, out_ready,
        input  in_ready, out_valid, out_data, out_is_imm, out_err
    );

    modport slave (
        input  in_valid, reg_data, imm, sel, ext_mode, out_ready,
        output in_ready, out_valid, out_data, out_is_imm, out_err
    );
endinterface

// File: rtl/operand_sel_stage.sv
// Registered operand-B select stage: register operand or extended immediate, behind valid/ready.
// Macro OPSEL_SKID_EN selects a two-entry skid buffer with registered in_ready; otherwise a single register.
module operand_sel_stage #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int NUM_REG = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    operand_sel_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_REG + 2);
    localparam logic [SEL_W-1:0] IMM_SEL = SEL_W'(NUM_REG);

    // Mode 11 is illegal and yields zero; the error flag is raised separately.
    function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] raw,
                                                  input logic [1:0]       mode);
        logic signed [IMM_W-1:0] s;
        logic [DATA_W-1:0]       r;
        s = signed'(raw);
        case (mode)
            2'b00:   r = DATA_W'(s);
            2'b01:   r = DATA_W'(raw);
            2'b10:   r = DATA_W'(raw) << (DATA_W - IMM_W);
            default: r = '0;
        endcase
        return r;
    endfunction

    logic              in_ready;
    logic              vld_p0;
    logic              xout;
    logic [DATA_W-1:0] data_p0;
    logic              is_imm_p0;
    logic              err_p0;

    // stage p0: combinational operand select / extend
    always_comb begin
        data_p0   = '0;
        is_imm_p0 = 1'b0;
        err_p0    = 1'b0;
        if (bus.sel < IMM_SEL) begin
            for (int k = 0; k < NUM_REG; k++) begin
                if (bus.sel == SEL_W'(k)) data_p0 = bus.reg_data[k*DATA_W +: DATA_W];
            end
        end else if (bus.sel == IMM_SEL) begin
            is_imm_p0 = 1'b1;
            err_p0    = (bus.ext_mode == 2'b11);
            data_p0   = ext_imm(bus.imm, bus.ext_mode);
        end else begin
            err_p0    = 1'b1;
        end
    end

    assign vld_p0 = bus.in_valid & in_ready;

`ifdef OPSEL_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state_q, state_d;
    logic              rdy_q;
    logic              load_main, load_skid, move_skid;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1, skid_data_p1;
    logic              is_imm_p1, skid_is_imm_p1;
    logic              err_p1, skid_err_p1;

    assign vld_p1   = (state_q != EMPTY);
    assign in_ready = rst_n & rdy_q;
    assign xout     = vld_p1 & bus.out_ready;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state_q)
            EMPTY: if (vld_p0) begin
                state_d   = ONE;
                load_main = 1'b1;
            end
            ONE: begin
                if (vld_p0 && xout) begin
                    load_main = 1'b1;
                end else if (vld_p0) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (xout) begin
                    state_d   = EMPTY;
                end
            end
            TWO: if (xout) begin
                state_d   = ONE;
                move_skid = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
    end

    // stage p1: main output register plus skid register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= EMPTY;
            rdy_q          <= 1'b0;
            data_p1        <= '0;
            is_imm_p1      <= 1'b0;
            err_p1         <= 1'b0;
            skid_data_p1   <= '0;
            skid_is_imm_p1 <= 1'b0;
            skid_err_p1    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != TWO);
            if (load_main) begin
                data_p1   <= data_p0;
                is_imm_p1 <= is_imm_p0;
                err_p1    <= err_p0;
            end else if (move_skid) begin
                data_p1   <= skid_data_p1;
                is_imm_p1 <= skid_is_imm_p1;
                err_p1    <= skid_err_p1;
            end
            if (load_skid) begin
                skid_data_p1   <= data_p0;
                skid_is_imm_p1 <= is_imm_p0;
                skid_err_p1    <= err_p0;
            end
        end
    end
`else
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic              is_imm_p1;
    logic              err_p1;

    // Ready passes straight through from out_ready so a draining beat can be replaced in place.
    assign in_ready = rst_n & (~vld_p1 | bus.out_ready);
    assign xout     = vld_p1 & bus.out_ready;

    // stage p1: single output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            is_imm_p1 <= 1'b0;
            err_p1    <= 1'b0;
        end else if (vld_p0) begin
            vld_p1    <= 1'b1;
            data_p1   <= data_p0;
            is_imm_p1 <= is_imm_p0;
            err_p1    <= err_p0;
        end else if (xout) begin
            vld_p1    <= 1'b0;
        end
    end
`endif

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = vld_p1;
    assign bus.out_data   = data_p1;
    assign bus.out_is_imm = is_imm_p1;
    assign bus.out_err    = err_p1;
endmodule

// File: tb/tb_operand_sel_stage.sv
// Self-checking bench for operand_sel_stage: directed scenarios plus randomized traffic against a reference model.
module tb_operand_sel_stage;
    localparam int DATA_W  = 32;
    localparam int IMM_W   = 16;
    localparam int NUM_REG = 2;

    typedef struct {
        logic [31:0] r0;
        logic [31:0] r1;
        logic [15:0] imm;
        logic [1:0]  sel;
        logic [1:0]  mode;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    beat_t       bq[$];
    logic [31:0] obs_data[$];
    logic        obs_imm[$];
    logic        obs_err[$];
    int          obs_cyc[$];
    int          acc_hold;
    logic        rdy_hold;
    int          hold_changes;

    operand_sel_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .NUM_REG(NUM_REG)) bus ();

    operand_sel_stage #(.DATA_W(DATA_W), .IMM_W(IMM_W), .NUM_REG(NUM_REG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_data(input beat_t b);
        longint v;
        v = 0;
        if (b.sel == 2'd0) v = b.r0;
        else if (b.sel == 2'd1) v = b.r1;
        else if (b.sel == 2'd2) begin
            v = b.imm;
            if (b.mode == 2'd0 && v >= (longint'(1) << (IMM_W - 1))) v = v - (longint'(1) << IMM_W);
            else if (b.mode == 2'd2) v = v * (longint'(1) << (DATA_W - IMM_W));
            else if (b.mode == 2'd3) v = 0;
        end
        return v[31:0];
    endfunction

    function automatic logic ref_is_imm(input beat_t b);
        return (b.sel == 2'd2);
    endfunction

    function automatic logic ref_err(input beat_t b);
        return (b.sel == 2'd3) || (b.sel == 2'd2 && b.mode == 2'd3);
    endfunction

    function automatic beat_t mk(input logic [31:0] r0, input logic [31:0] r1,
                                 input logic [15:0] imm, input logic [1:0] sel,
                                 input logic [1:0] mode);
        beat_t b;
        b.r0 = r0; b.r1 = r1; b.imm = imm; b.sel = sel; b.mode = mode;
        return b;
    endfunction

    task automatic drive(input beat_t b, input logic v);
        bus.in_valid = v;
        bus.reg_data = {b.r1, b.r0};
        bus.imm      = b.imm;
        bus.sel      = b.sel;
        bus.ext_mode = b.mode;
    endtask

    // Offers one beat with out_ready=1 and captures the registered output one edge later.
    task automatic do_beat(input beat_t b, output logic acc, output logic v,
                           output logic [31:0] d, output logic ii, output logic e);
        drive(b, 1'b1);
        bus.out_ready = 1'b1;
        #1;
        acc = bus.in_ready;
        @(posedge clk); #1;
        v  = bus.out_valid;
        d  = bus.out_data;
        ii = bus.out_is_imm;
        e  = bus.out_err;
        bus.in_valid = 1'b0;
    endtask

    // rmode 0: out_ready=1; 1: random; 2: out_ready=0 for the first 'hold' cycles.
    task automatic run_stream(input int rmode, input int hold, input int budget);
        int   idx;
        int   cyc;
        logic prev_stall;
        logic [31:0] prev_d;
        idx = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0;
        hold_changes = 0; acc_hold = -1; rdy_hold = 1'bx;
        obs_data.delete(); obs_imm.delete(); obs_err.delete(); obs_cyc.delete();
        while (obs_data.size() < bq.size() && cyc < budget) begin
            if (rmode == 2 && cyc == hold) begin
                acc_hold = idx;
                rdy_hold = bus.in_ready;
            end
            if (idx < bq.size()) drive(bq[idx], 1'b1);
            else bus.in_valid = 1'b0;
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = (cyc >= hold);
            endcase
            #1;
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid && bus.out_ready) begin
                obs_data.push_back(bus.out_data);
                obs_imm.push_back(bus.out_is_imm);
                obs_err.push_back(bus.out_err);
                obs_cyc.push_back(cyc);
                prev_stall = 1'b0;
            end else if (bus.out_valid) begin
                if (prev_stall && bus.out_data !== prev_d) hold_changes++;
                prev_stall = 1'b1;
                prev_d     = bus.out_data;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.reg_data = '0; bus.imm = '0; bus.sel = '0; bus.ext_mode = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_is_imm !== 1'b0 ||
            bus.out_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b d=%h imm=%b err=%b want 0/0/0/0",
                     bus.out_valid, bus.out_data, bus.out_is_imm, bus.out_err);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reg_select();
        logic acc, v, ii, e;
        logic [31:0] d;
        for (int s = 0; s < 2; s++) begin
            beat_t b;
            b = mk(32'h1234_5678, 32'hDEAD_BEEF, 16'h5555, 2'(s), 2'(s + 2));
            do_beat(b, acc, v, d, ii, e);
            checks++;
            if (!acc || v !== 1'b1 || d !== (s == 0 ? 32'h1234_5678 : 32'hDEAD_BEEF) ||
                ii !== 1'b0 || e !== 1'b0) begin
                failures++;
                $display("FAIL reg_sel%0d: got acc=%b v=%b d=%h imm=%b err=%b want 1/1/%h/0/0",
                         s, acc, v, d, ii, e, (s == 0 ? 32'h1234_5678 : 32'hDEAD_BEEF));
            end
        end
    endtask

    task automatic test_imm_ext();
        logic acc, v, ii, e;
        logic [31:0] d;
        logic [31:0] want[3];
        beat_t b;
        want[0] = 32'hFFFF_8001; want[1] = 32'h0000_8001; want[2] = 32'h8001_0000;
        for (int m = 0; m < 3; m++) begin
            b = mk(32'h1111_1111, 32'h2222_2222, 16'h8001, 2'd2, 2'(m));
            do_beat(b, acc, v, d, ii, e);
            checks++;
            if (!acc || v !== 1'b1 || d !== want[m] || ii !== 1'b1 || e !== 1'b0) begin
                failures++;
                $display("FAIL imm_mode%0d: got v=%b d=%h imm=%b err=%b want 1/%h/1/0",
                         m, v, d, ii, e, want[m]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            b = mk($urandom, $urandom, 16'($urandom), 2'd2, 2'($urandom_range(0, 2)));
            do_beat(b, acc, v, d, ii, e);
            checks++;
            if (!acc || v !== 1'b1 || d !== ref_data(b) || ii !== 1'b1 || e !== 1'b0) begin
                failures++;
                $display("FAIL imm_rand%0d: imm=%h mode=%0d got d=%h imm=%b err=%b want %h/1/0",
                         i, b.imm, b.mode, d, ii, e, ref_data(b));
            end
        end
    endtask

    task automatic test_err();
        logic acc, v, ii, e;
        logic [31:0] d;
        beat_t b;
        b = mk(32'hAAAA_AAAA, 32'hBBBB_BBBB, 16'h8001, 2'd3, 2'd0);
        do_beat(b, acc, v, d, ii, e);
        checks++;
        if (!acc || v !== 1'b1 || d !== 32'h0 || ii !== 1'b0 || e !== 1'b1) begin
            failures++;
            $display("FAIL err_sel: got v=%b d=%h imm=%b err=%b want 1/0/0/1", v, d, ii, e);
        end
        b = mk(32'hAAAA_AAAA, 32'hBBBB_BBBB, 16'h8001, 2'd2, 2'd3);
        do_beat(b, acc, v, d, ii, e);
        checks++;
        if (!acc || v !== 1'b1 || d !== 32'h0 || ii !== 1'b1 || e !== 1'b1) begin
            failures++;
            $display("FAIL err_mode: got v=%b d=%h imm=%b err=%b want 1/0/1/1", v, d, ii, e);
        end
        b = mk(32'hAAAA_AAAA, 32'hBBBB_BBBB, 16'h8001, 2'd1, 2'd3);
        do_beat(b, acc, v, d, ii, e);
        checks++;
        if (!acc || v !== 1'b1 || d !== 32'hBBBB_BBBB || ii !== 1'b0 || e !== 1'b0) begin
            failures++;
            $display("FAIL reg_mode_ignored: got v=%b d=%h imm=%b err=%b want 1/bbbbbbbb/0/0",
                     v, d, ii, e);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int want_acc;
`ifdef OPSEL_SKID_EN
        want_acc = 2;
`else
        want_acc = 1;
`endif
        bq.delete();
        bq.push_back(mk(32'hA000_000A, 32'h0, 16'h0, 2'd0, 2'd0));
        bq.push_back(mk(32'hB000_000B, 32'h0, 16'h0, 2'd0, 2'd0));
        bq.push_back(mk(32'hC000_000C, 32'h0, 16'h0, 2'd0, 2'd0));
        run_stream(2, 4, 40);
        checks++;
        if (acc_hold != want_acc || rdy_hold !== 1'b0) begin
            failures++;
            $display("FAIL stall_accept: got accepted=%0d in_ready=%b want %0d/0",
                     acc_hold, rdy_hold, want_acc);
        end
        checks++;
        if (hold_changes != 0) begin
            failures++;
            $display("FAIL stall_hold: got %0d output changes while stalled want 0", hold_changes);
        end
        checks++;
        if (obs_data.size() != 3) begin
            failures++;
            $display("FAIL stall_count: got %0d beats want 3", obs_data.size());
        end
        for (int i = 0; i < obs_data.size() && i < 3; i++) begin
            checks++;
            if (obs_data[i] !== bq[i].r0) begin
                failures++;
                $display("FAIL stall_order%0d: got %h want %h", i, obs_data[i], bq[i].r0);
            end
        end
    endtask

    task automatic test_back_to_back();
        bq.delete();
        for (int i = 0; i < 8; i++)
            bq.push_back(mk($urandom, $urandom, 16'($urandom), 2'($urandom_range(0, 2)),
                            2'($urandom_range(0, 2))));
        run_stream(0, 0, 40);
        checks++;
        if (obs_data.size() != 8) begin
            failures++;
            $display("FAIL b2b_count: got %0d beats want 8", obs_data.size());
        end
        for (int i = 0; i < obs_data.size() && i < 8; i++) begin
            checks++;
            if (obs_data[i] !== ref_data(bq[i]) || obs_cyc[i] != i + 1) begin
                failures++;
                $display("FAIL b2b_beat%0d: got d=%h cyc=%0d want d=%h cyc=%0d",
                         i, obs_data[i], obs_cyc[i], ref_data(bq[i]), i + 1);
            end
        end
    endtask

    task automatic test_random();
        bq.delete();
        for (int i = 0; i < 40; i++)
            bq.push_back(mk($urandom, $urandom, 16'($urandom), 2'($urandom_range(0, 3)),
                            2'($urandom_range(0, 3))));
        run_stream(1, 0, 800);
        checks++;
        if (obs_data.size() != bq.size()) begin
            failures++;
            $display("FAIL rand_count: got %0d beats want %0d", obs_data.size(), bq.size());
        end
        for (int i = 0; i < obs_data.size() && i < bq.size(); i++) begin
            checks++;
            if (obs_data[i] !== ref_data(bq[i]) || obs_imm[i] !== ref_is_imm(bq[i]) ||
                obs_err[i] !== ref_err(bq[i])) begin
                failures++;
                $display("FAIL rand_beat%0d: sel=%0d mode=%0d got %h/%b/%b want %h/%b/%b",
                         i, bq[i].sel, bq[i].mode, obs_data[i], obs_imm[i], obs_err[i],
                         ref_data(bq[i]), ref_is_imm(bq[i]), ref_err(bq[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        int leaked;
        bus.out_ready = 1'b0;
        drive(mk(32'h5A5A_5A5A, 32'h0, 16'h0, 2'd0, 2'd0), 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h5A5A_5A5A) begin
            failures++;
            $display("FAIL mid_setup: got v=%b d=%h want 1/5a5a5a5a", bus.out_valid, bus.out_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_rdy_in_reset: got %b want 0", bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            failures++;
            $display("FAIL mid_flush: got v=%b d=%h want 0/0", bus.out_valid, bus.out_data);
        end
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_rdy_after: got %b want 1", bus.in_ready);
        end
        leaked = 0;
        repeat (4) begin
            if (bus.out_valid !== 1'b0) leaked++;
            @(posedge clk); #1;
        end
        checks++;
        if (leaked != 0) begin
            failures++;
            $display("FAIL mid_no_emit: got %0d valid cycles after reset want 0", leaked);
        end
    endtask

    initial begin
        test_reset();
        test_reg_select();
        test_imm_ext();
        test_err();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
